// File: rtl/snn_pkg.sv
// Shared definitions for the spiking step sequencer: register map, sequencer states
// and the saturating adder used by both the accumulator and the membrane update.
package snn_pkg;

  localparam logic [6:0] ADDR_CTRL        = 7'h00;
  localparam logic [6:0] ADDR_SPIKE_IN    = 7'h01;
  localparam logic [6:0] ADDR_STATUS      = 7'h02;
  localparam logic [6:0] ADDR_THRESH      = 7'h03;
  localparam logic [6:0] ADDR_LEAK        = 7'h04;
  localparam logic [6:0] ADDR_WEIGHT_BASE = 7'h10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIRE  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Adds two sign-extended operands and clamps to the signed range of 'width' bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int width);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo  = -hi - 33'sd1;
    if (sum > hi) begin
      sat_add = hi[31:0];
    end else if (sum < lo) begin
      sat_add = lo[31:0];
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/snn_step_sequencer_if.sv
// Decoded command stream from the SPI slave plus the read-response channel.
interface snn_step_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [6:0]  cmd_addr;
  logic [23:0] cmd_wdata;
  logic        rsp_valid;
  logic [23:0] rsp_rdata;

  modport master (output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
                  input  cmd_ready, rsp_valid, rsp_rdata);
  modport slave  (input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
                  output cmd_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/snn_neuron_update.sv
// Combinational leak, saturating integrate and threshold compare for one neuron.
module snn_neuron_update
  import snn_pkg::*;
#(
  parameter int MEM_W = 16
) (
  input  logic signed [MEM_W-1:0] i_mem,
  input  logic signed [MEM_W-1:0] i_acc,
  input  logic signed [MEM_W-1:0] i_thresh,
  input  logic [3:0]              i_leak_shift,
  output logic signed [MEM_W-1:0] o_next_mem,
  output logic                    o_fire
);
  logic signed [31:0] w_mem;
  logic signed [31:0] w_leak;
  logic signed [31:0] w_diff;
  logic signed [31:0] w_v;

  // A shift of MEM_W or more disables leak; a plain >>> would leave -1 for negative membranes.
  always_comb begin
    w_mem  = 32'(i_mem);
    w_leak = (int'(i_leak_shift) >= MEM_W) ? 32'sd0 : (w_mem >>> i_leak_shift);
    w_diff = w_mem - w_leak;
    w_v    = sat_add(w_diff, 32'(i_acc), MEM_W);
    o_fire = (w_v >= 32'(i_thresh));
    if (o_fire) begin
      o_next_mem = '0;
    end else begin
      o_next_mem = w_v[MEM_W-1:0];
    end
  end
endmodule

// File: rtl/snn_step_sequencer.sv
// Register-mapped controller running one integrate-leak-fire timestep per SPIKE_IN write.
// Build option SNN_REFRACTORY_EN: a neuron that spiked last step sits out the next one.
module snn_step_sequencer
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int MEM_W = 16,
  parameter int W_W = 8,
  parameter logic signed [MEM_W-1:0] THRESH_DEF = 16'sd64
) (
  input  logic                   sclk,
  input  logic                   rst,
  snn_step_sequencer_if.slave    cmd,
  output logic                   busy,
  output logic                   step_done,
  output logic [NUM_NEURONS-1:0] out_spikes
);
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int NW    = NUM_NEURONS * NUM_NEURONS;
  localparam int K_W   = 2 * IDX_W;

  state_t r_state, w_state_nxt;
  logic                    r_run, r_busy, r_step_done, r_rsp_valid;
  logic [23:0]             r_rsp_rdata, w_rdata;
  logic [3:0]              r_leak_shift;
  logic signed [MEM_W-1:0] r_thresh, r_acc;
  logic signed [W_W-1:0]   r_w [NW];
  logic signed [MEM_W-1:0] r_mem [NUM_NEURONS];
  logic [IDX_W-1:0]        r_i, r_j;
  logic [NUM_NEURONS-1:0]  r_spk_in, r_new_spk, r_out_spikes, w_spk_vec;
  logic w_accept, w_wr, w_rd, w_start, w_is_weight, w_last_i, w_last_j, w_fire, w_refr;
  logic [6:0]              w_woff;
  logic signed [31:0]      w_acc_sum;
  logic signed [MEM_W-1:0] w_next_mem;
  logic                    w_unused;

  assign w_accept    = cmd.cmd_valid && !r_busy;
  assign w_wr        = w_accept && !cmd.cmd_rw;
  assign w_rd        = w_accept && cmd.cmd_rw;
  assign w_start     = w_wr && (cmd.cmd_addr == ADDR_SPIKE_IN) && r_run;
  assign w_woff      = cmd.cmd_addr - ADDR_WEIGHT_BASE;
  assign w_is_weight = (cmd.cmd_addr >= ADDR_WEIGHT_BASE) && ({25'd0, w_woff} < 32'(NW));
  assign w_last_i    = (r_i == IDX_W'(NUM_NEURONS - 1));
  assign w_last_j    = (r_j == IDX_W'(NUM_NEURONS - 1));
  assign w_acc_sum   = sat_add(32'(r_acc), 32'(r_w[{r_j, r_i}]), MEM_W);
  assign w_unused    = ^cmd.cmd_wdata[23:MEM_W];

`ifdef SNN_REFRACTORY_EN
  assign w_refr = r_out_spikes[r_j];
`else
  assign w_refr = 1'b0;
`endif

  snn_neuron_update #(.MEM_W(MEM_W)) u_update (
    .i_mem        (r_mem[r_j]),
    .i_acc        (r_acc),
    .i_thresh     (r_thresh),
    .i_leak_shift (r_leak_shift),
    .o_next_mem   (w_next_mem),
    .o_fire       (w_fire)
  );

  assign cmd.cmd_ready = !r_busy;
  assign cmd.rsp_valid = r_rsp_valid;
  assign cmd.rsp_rdata = r_rsp_rdata;
  assign busy          = r_busy;
  assign step_done     = r_step_done;
  assign out_spikes    = r_out_spikes;

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_start ? ACCUM : IDLE;
      ACCUM:   w_state_nxt = w_last_i ? FIRE : ACCUM;
      FIRE:    w_state_nxt = w_last_j ? DONE : ACCUM;
      DONE:    w_state_nxt = w_start ? ACCUM : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_rdata = 24'd0;
    if (cmd.cmd_addr == ADDR_CTRL) begin
      w_rdata = {22'd0, r_busy, r_run};
    end else if (cmd.cmd_addr == ADDR_STATUS) begin
      w_rdata = 24'(r_out_spikes);
    end else if (cmd.cmd_addr == ADDR_THRESH) begin
      w_rdata = 24'(r_thresh);
    end else if (cmd.cmd_addr == ADDR_LEAK) begin
      w_rdata = {20'd0, r_leak_shift};
    end else if (w_is_weight) begin
      w_rdata = 24'(r_w[w_woff[K_W-1:0]]);
    end else begin
      w_rdata = 24'd0;
    end
  end

  always_comb begin
    w_spk_vec      = r_new_spk;
    w_spk_vec[r_j] = w_fire && !w_refr;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_run        <= 1'b0;
      r_busy       <= 1'b0;
      r_step_done  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= 24'd0;
      r_leak_shift <= 4'd0;
      r_thresh     <= THRESH_DEF;
      r_acc        <= '0;
      r_i          <= '0;
      r_j          <= '0;
      r_spk_in     <= '0;
      r_new_spk    <= '0;
      r_out_spikes <= '0;
      for (int k = 0; k < NW; k++) r_w[k] <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) r_mem[n] <= '0;
    end else begin
      r_rsp_valid <= w_rd;
      r_rsp_rdata <= w_rd ? w_rdata : 24'd0;
      r_step_done <= 1'b0;
      if (w_wr) begin
        if (cmd.cmd_addr == ADDR_CTRL) r_run <= cmd.cmd_wdata[0];
        if (cmd.cmd_addr == ADDR_THRESH) r_thresh <= cmd.cmd_wdata[MEM_W-1:0];
        if (cmd.cmd_addr == ADDR_LEAK) r_leak_shift <= cmd.cmd_wdata[3:0];
        if (w_is_weight) r_w[w_woff[K_W-1:0]] <= cmd.cmd_wdata[W_W-1:0];
      end
      if (w_start) begin
        r_spk_in  <= cmd.cmd_wdata[NUM_NEURONS-1:0];
        r_i       <= '0;
        r_j       <= '0;
        r_acc     <= '0;
        r_new_spk <= '0;
        r_busy    <= 1'b1;
      end
      case (r_state)
        ACCUM: begin
          if (r_spk_in[r_i]) r_acc <= w_acc_sum[MEM_W-1:0];
          r_i <= r_i + 1'b1;
        end
        FIRE: begin
          r_mem[r_j] <= w_refr ? '0 : w_next_mem;
          r_new_spk  <= w_spk_vec;
          r_acc      <= '0;
          r_i        <= '0;
          r_j        <= r_j + 1'b1;
          if (w_last_j) begin
            r_busy       <= 1'b0;
            r_step_done  <= 1'b1;
            r_out_spikes <= w_spk_vec;
          end
        end
        default: ;
      endcase
      // With the core stopped, membranes and the spike monitor stay cleared.
      if (!r_run) begin
        r_out_spikes <= '0;
        for (int n = 0; n < NUM_NEURONS; n++) r_mem[n] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_snn_step_sequencer.sv
// Randomized bench for snn_step_sequencer against a per-step arithmetic model of the core.
module tb_snn_step_sequencer;
  localparam int N   = 4;
  localparam int LAT = N * (N + 1) + 1;
`ifdef SNN_REFRACTORY_EN
  localparam bit REFR = 1'b1;
`else
  localparam bit REFR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy, step_done;
  logic [N-1:0] out_spikes;

  snn_step_sequencer_if bus();

  snn_step_sequencer #(.NUM_NEURONS(N)) dut (
    .sclk       (clk),
    .rst        (rst),
    .cmd        (bus),
    .busy       (busy),
    .step_done  (step_done),
    .out_spikes (out_spikes)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int m_w [N*N];
  int m_mem [N];
  int m_thresh, m_leak;
  logic m_run;
  logic [N-1:0] m_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_reset();
    foreach (m_w[k]) m_w[k] = 0;
    foreach (m_mem[n]) m_mem[n] = 0;
    m_thresh = 64;
    m_leak   = 0;
    m_run    = 1'b0;
    m_out    = '0;
  endtask

  task automatic model_write(input logic [6:0] a, input logic [23:0] d);
    if (a == 7'h00) begin
      m_run = d[0];
      if (!m_run) begin
        foreach (m_mem[n]) m_mem[n] = 0;
        m_out = '0;
      end
    end else if (a == 7'h03) begin
      m_thresh = int'($signed(d[15:0]));
    end else if (a == 7'h04) begin
      m_leak = int'(d[3:0]);
    end else if (a >= 7'h10 && int'(a) < 16 + N * N) begin
      m_w[int'(a) - 16] = int'($signed(d[7:0]));
    end
  endtask

  function automatic logic [23:0] model_read(input logic [6:0] a);
    if (a == 7'h00) return {23'd0, m_run};
    if (a == 7'h02) return 24'(m_out);
    if (a == 7'h03) return 24'(m_thresh);
    if (a == 7'h04) return 24'(m_leak);
    if (a >= 7'h10 && int'(a) < 16 + N * N) return 24'(m_w[int'(a) - 16]);
    return 24'd0;
  endfunction

  // One timestep of the core: weighted input sum, leak, threshold, reset on fire.
  task automatic model_step(input logic [N-1:0] spk);
    logic [N-1:0] nxt;
    int acc, leak, v;
    nxt = '0;
    for (int j = 0; j < N; j++) begin
      if (REFR && m_out[j]) begin
        m_mem[j] = 0;
      end else begin
        acc = 0;
        for (int i = 0; i < N; i++) if (spk[i]) acc = clamp(acc + m_w[j*N + i]);
        leak = (m_leak >= 16) ? 0 : (m_mem[j] >>> m_leak);
        v = clamp(m_mem[j] - leak + acc);
        if (v >= m_thresh) begin
          nxt[j] = 1'b1;
          m_mem[j] = 0;
        end else begin
          m_mem[j] = v;
        end
      end
    end
    m_out = nxt;
  endtask

  task automatic wr(input logic [6:0] a, input logic [23:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    tick();
    bus.cmd_valid = 1'b0;
    if (a != 7'h01) model_write(a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a);
    logic [23:0] exp;
    exp = model_read(a);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_wdata = 24'd0;
    tick();
    bus.cmd_valid = 1'b0;
    chk({tag, "_vld"}, 32'(bus.rsp_valid), 32'd1);
    chk(tag, 32'(bus.rsp_rdata), 32'(exp));
  endtask

  task automatic do_step(input logic [N-1:0] spk);
    int n;
    bit seen;
    wr(7'h01, 24'(spk));
    if (m_run) begin
      model_step(spk);
      chk("busy_c1", 32'(busy), 32'd1);
      n = 1;
      while (!step_done && n < 200) begin
        tick();
        n++;
      end
      chk("step_lat", n, LAT);
      chk("spikes", 32'(out_spikes), 32'(m_out));
      chk("ready_done", 32'(bus.cmd_ready), 32'd1);
    end else begin
      seen = 1'b0;
      repeat (LAT + 3) begin
        if (busy || step_done) seen = 1'b1;
        tick();
      end
      chk("run0_idle", 32'(seen), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    logic [6:0] a;
    logic [23:0] d;
    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = 7'd0;
    bus.cmd_wdata = 24'd0;
    do_reset();

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(step_done), 32'd0);
    chk("rst_spk", 32'(out_spikes), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rsp", 32'(bus.rsp_valid), 32'd0);
    rd_chk("rd_status", 7'h02);
    rd_chk("rd_ctrl", 7'h00);
    rd_chk("rd_thresh", 7'h03);
    tick();
    chk("rsp_idle_vld", 32'(bus.rsp_valid), 32'd0);
    chk("rsp_idle_data", 32'(bus.rsp_rdata), 32'd0);
    do_step(4'h3);

    // Basic fire, then a second step that exercises refractory when enabled.
    wr(7'h00, 24'd1);
    wr(7'h03, 24'd10);
    wr(7'h10, 24'd6);
    wr(7'h11, 24'd5);
    do_step(4'h3);
    rd_chk("basic_status", 7'h02);
    do_step(4'h3);
    rd_chk("rd_ctrl_run", 7'h00);
    rd_chk("rd_w0", 7'h10);

    wr(7'h14, 24'd4);
    wr(7'h04, 24'd1);
    repeat (6) do_step(4'h1);
    wr(7'h04, 24'd15);
    repeat (6) do_step(4'h1);

    for (int k = 0; k < N; k++) wr(7'(16 + k), 24'h000080);
    rd_chk("rd_wneg", 7'h10);
    repeat (70) do_step(4'hF);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: wr(7'(16 + $urandom_range(0, N*N - 1)), 24'($urandom));
        3: wr(7'h03, {8'($urandom), 16'($urandom_range(0, 140) - 20)});
        4: wr(7'h04, 24'($urandom));
        5: begin
          a = 7'($urandom);
          rd_chk("rnd_rd", a);
          wr(7'($urandom_range(32, 127)), 24'($urandom));
        end
        6: wr(7'h00, 24'($urandom_range(0, 3) != 0));
        default: do_step(N'($urandom));
      endcase
    end

    // Read held through a step: accepted in the step_done cycle.
    wr(7'h00, 24'd1);
    d = 24'($urandom);
    wr(7'h01, d);
    model_step(d[N-1:0]);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b1;
    bus.cmd_addr  = 7'h02;
    n = 1;
    while (!bus.cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk("bp_ready_cyc", n, LAT);
    chk("bp_done", 32'(step_done), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("bp_rsp_vld", 32'(bus.rsp_valid), 32'd1);
    chk("bp_rsp_data", 32'(bus.rsp_rdata), 32'(m_out));

    // Reset in cycle 7 of a step.
    wr(7'h10, 24'd50);
    wr(7'h03, 24'd1);
    do_step(4'hF);
    chk("pre_rst_spk", 32'(out_spikes != '0), 32'd1);
    wr(7'h01, 24'hF);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_spk", 32'(out_spikes), 32'd0);
    chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
    rd_chk("mid_rst_w0", 7'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
